// File: rtl/trg_stim_gen.sv
// Trigger-stimulus transmitter: pre-LCT, optional CLCT and L1A/BGTRG with fixed latency and gap.
// Define TRG_STIM_CLCT_EN to drive CLCT from LCT_MASK[5:1] alongside PRE_LCT.
module trg_stim_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [5:0]       LCT_MASK,
  input  logic [CNT_W-1:0] L1A_DLY,
  input  logic [CNT_W-1:0] GAP,
  input  logic [CNT_W-1:0] NTRIG,
  input  logic             SEND_L1A,
  output logic [5:0]       PRE_LCT,
  output logic [4:0]       CLCT,
  output logic             L1A,
  output logic             BGTRG,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] TRGCNT
);

  typedef enum logic [2:0] {StIdle, StLct, StWait, StL1a, StGap} state_e;

  state_e           state_q;
  logic [5:0]       mask_q;
  logic [CNT_W-1:0] dly_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] ntrig_q;
  logic             send_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_pend_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      dly_q       <= CNT_W'(1);
      gap_q       <= '0;
      ntrig_q     <= '0;
      send_q      <= 1'b0;
      cnt_q       <= '0;
      done_pend_q <= 1'b0;
      PRE_LCT     <= '0;
      L1A         <= 1'b0;
      BGTRG       <= 1'b1;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      TRGCNT      <= '0;
    end else begin
      PRE_LCT <= '0;
      L1A     <= 1'b0;
      BGTRG   <= 1'b1;
      DONE    <= 1'b0;
      if (ABORT) begin
        state_q     <= StIdle;
        BUSY        <= 1'b0;
        done_pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // The last L1A slot returns here with a pending DONE so BUSY falls one cycle later.
            if (done_pend_q) begin
              DONE        <= 1'b1;
              BUSY        <= 1'b0;
              done_pend_q <= 1'b0;
            end else if (START) begin
              mask_q  <= LCT_MASK;
              dly_q   <= (L1A_DLY == '0) ? CNT_W'(1) : L1A_DLY;
              gap_q   <= GAP;
              ntrig_q <= NTRIG;
              send_q  <= SEND_L1A;
              TRGCNT  <= '0;
              BUSY    <= 1'b1;
              state_q <= StLct;
            end
          end
          StLct: begin
            PRE_LCT <= mask_q;
            TRGCNT  <= TRGCNT + CNT_W'(1);
            if (dly_q > CNT_W'(1)) begin
              cnt_q   <= dly_q - CNT_W'(2);
              state_q <= StWait;
            end else begin
              state_q <= StL1a;
            end
          end
          StWait: begin
            if (cnt_q == '0) state_q <= StL1a;
            else cnt_q <= cnt_q - CNT_W'(1);
          end
          StL1a: begin
            L1A   <= send_q;
            BGTRG <= ~send_q;
            if (ntrig_q != '0 && TRGCNT == ntrig_q) begin
              done_pend_q <= 1'b1;
              state_q     <= StIdle;
            end else if (gap_q != '0) begin
              cnt_q   <= gap_q - CNT_W'(1);
              state_q <= StGap;
            end else begin
              state_q <= StLct;
            end
          end
          StGap: begin
            if (cnt_q == '0) state_q <= StLct;
            else cnt_q <= cnt_q - CNT_W'(1);
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef TRG_STIM_CLCT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CLCT <= '0;
    end else if (!ABORT && state_q == StLct) begin
      CLCT <= mask_q[5:1];
    end else begin
      CLCT <= '0;
    end
  end
`else
  assign CLCT = '0;
`endif

endmodule

// File: tb/tb_trg_stim_gen.sv
// Self-checking bench for trg_stim_gen: timing-formula model feeding a scoreboard queue,
// plus hand sequences for reset, abort/wrap, START-while-busy and async reset.
module tb_trg_stim_gen;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [5:0] LCT_MASK = '0;
  logic [7:0] L1A_DLY = '0;
  logic [7:0] GAP = '0;
  logic [7:0] NTRIG = '0;
  logic       SEND_L1A = 1'b0;
  logic [5:0] PRE_LCT;
  logic [4:0] CLCT;
  logic       L1A;
  logic       BGTRG;
  logic       BUSY;
  logic       DONE;
  logic [7:0] TRGCNT;

  trg_stim_gen #(.CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .LCT_MASK(LCT_MASK),
    .L1A_DLY(L1A_DLY), .GAP(GAP), .NTRIG(NTRIG), .SEND_L1A(SEND_L1A),
    .PRE_LCT(PRE_LCT), .CLCT(CLCT), .L1A(L1A), .BGTRG(BGTRG), .BUSY(BUSY),
    .DONE(DONE), .TRGCNT(TRGCNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] mask;
    logic [7:0] dly;
    logic [7:0] gap;
    logic [7:0] ntrig;
    logic       send;
  } vec_t;

  typedef struct {
    int          e;
    logic [22:0] outs;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   l1a_seen = 0;
  int   done_seen = 0;

  localparam logic [22:0] RstOuts = {6'h00, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

  always @(negedge CLK) begin
    if (L1A) l1a_seen++;
    if (DONE) done_seen++;
  end

  function automatic logic [22:0] outs_now();
    return {PRE_LCT, CLCT, L1A, BGTRG, BUSY, DONE, TRGCNT};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected trace from the published edge formulas; sampled #1 after edges 0..done.
  task automatic build_expect(input vec_t v);
    int d, p, n, done_e, cnt;
    logic pre, l1a;
    logic [4:0] clct_exp;
    d = (v.dly == 0) ? 1 : int'(v.dly);
    p = d + 1 + int'(v.gap);
    n = int'(v.ntrig);
    done_e = 2 + d + (n - 1) * p;
    for (int e = 0; e <= done_e; e++) begin
      exp_t x;
      pre = 1'b0;
      l1a = 1'b0;
      cnt = 0;
      for (int k = 0; k < n; k++) begin
        if (e == 1 + k * p) pre = 1'b1;
        if (e == 1 + d + k * p) l1a = 1'b1;
        if (1 + k * p <= e) cnt++;
      end
`ifdef TRG_STIM_CLCT_EN
      clct_exp = pre ? v.mask[5:1] : 5'h00;
`else
      clct_exp = 5'h00;
`endif
      x.e = e;
      x.outs = {pre ? v.mask : 6'h00, clct_exp, l1a & v.send, ~(l1a & v.send),
                e < done_e, e == done_e, 8'(cnt)};
      sb.push_back(x);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t x;
    @(negedge CLK);
    LCT_MASK = v.mask; L1A_DLY = v.dly; GAP = v.gap; NTRIG = v.ntrig; SEND_L1A = v.send;
    START = 1'b1;
    build_expect(v);
    @(posedge CLK);
    #1;
    START = 1'b0;
    // Latched config must not follow later input changes.
    LCT_MASK = ~v.mask; L1A_DLY = 8'hFF; GAP = 8'hFF; NTRIG = 8'h00; SEND_L1A = ~v.send;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check($sformatf("vec%0d_edge%0d", idx, x.e), 32'(outs_now()), 32'(x.outs));
      if (sb.size() > 0) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  initial begin
    int l1a_base, done_base;
    vecs[0] = '{mask: 6'h3F, dly: 8'd10, gap: 8'd0, ntrig: 8'd1, send: 1'b1};
    vecs[1] = '{mask: 6'h15, dly: 8'd0,  gap: 8'd3, ntrig: 8'd3, send: 1'b1};
    vecs[2] = '{mask: 6'h2A, dly: 8'd4,  gap: 8'd0, ntrig: 8'd2, send: 1'b0};
    vecs[3] = '{mask: 6'h2A, dly: 8'd1,  gap: 8'd1, ntrig: 8'd2, send: 1'b1};
    vecs[4] = '{mask: 6'h01, dly: 8'd3,  gap: 8'd5, ntrig: 8'd4, send: 1'b1};

    // Reset release, idle for 20 cycles.
    #12 RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("idle_after_reset_%0d", i), 32'(outs_now()), 32'(RstOuts));
    end

    // START with ABORT in IDLE: ABORT wins.
    @(negedge CLK);
    LCT_MASK = 6'h3F; L1A_DLY = 8'd2; NTRIG = 8'd1; SEND_L1A = 1'b1;
    START = 1'b1; ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0; ABORT = 1'b0;
    check("start_abort_idle", 32'(outs_now()), 32'(RstOuts));
    @(posedge CLK);
    #1;
    check("start_abort_idle_next", 32'(outs_now()), 32'(RstOuts));

    // Table vectors back-to-back: each START lands in the previous DONE cycle.
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    repeat (3) @(posedge CLK);
    #1;
    check("idle_after_table", 32'(outs_now()), 32'(RstOuts) | 32'(8'd4));

    // Continuous run, 300 triggers, abort during WAIT of the 300th.
    l1a_base = l1a_seen;
    done_base = done_seen;
    @(negedge CLK);
    LCT_MASK = 6'h3F; L1A_DLY = 8'd2; GAP = 8'd0; NTRIG = 8'd0; SEND_L1A = 1'b1;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0; LCT_MASK = 6'h00; NTRIG = 8'd1;
    for (int e = 1; e <= 898; e++) begin
      @(posedge CLK);
      #1;
      START = (e == 100);
      if (e == 101) check("busy_mid_run", 32'(BUSY), 32'd1);
    end
    START = 1'b0;
    check("cont_pre_300", 32'(PRE_LCT), 32'h3F);
    check("cont_trgcnt_wrap", 32'(TRGCNT), 32'd44);
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    check("abort_outputs", 32'(outs_now()), 32'(RstOuts) | 32'(8'd44));
    @(posedge CLK);
    #1;
    check("abort_no_l1a", 32'(outs_now()), 32'(RstOuts) | 32'(8'd44));
    @(posedge CLK);
    #1;
    check("cont_l1a_count", 32'(l1a_seen - l1a_base), 32'd299);
    check("cont_no_done", 32'(done_seen - done_base), 32'd0);

    // Asynchronous reset while PRE_LCT is high.
    @(negedge CLK);
    LCT_MASK = 6'h3F; L1A_DLY = 8'd3; GAP = 8'd0; NTRIG = 8'd1; SEND_L1A = 1'b1;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_pre_high", 32'(PRE_LCT), 32'h3F);
    #2 RST_N = 1'b0;
    #1;
    check("async_reset", 32'(outs_now()), 32'(RstOuts));
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("post_reset_%0d", i), 32'(outs_now()), 32'(RstOuts));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
